// File: rtl/fu_result_buffer.sv
// Per-FU result queue feeding the EX->WR arbiter.
// The head entry is held on ex_packet_out until the arbiter grants it.
package fu_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  tag;
    logic [4:0]  dest;
    logic [31:0] value;
  } ex_wr_packet_t;
endpackage

module fu_result_buffer
  import fu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          squash,
  input  ex_wr_packet_t fu_packet_in,
  output logic          fu_ready,
  output ex_wr_packet_t ex_packet_out,
  input  logic          written,
  output logic [CNT_W-1:0] count,
  output logic          overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ex_wr_packet_t    mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;
  ex_wr_packet_t    wr_pkt;

  // Wrap at DEPTH-1 so non power-of-2 depths stay in range.
  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(DEPTH - 1))
      return '0;
    return p + PTR_W'(1);
  endfunction

  assign fu_ready = (count < CNT_W'(DEPTH));
  assign push     = fu_packet_in.valid & fu_ready;
  assign pop      = written & (count != '0);

  always_comb begin
    wr_pkt       = fu_packet_in;
    wr_pkt.valid = 1'b1;
  end

  always_comb begin
    ex_packet_out = '0;
    if (count != '0)
      ex_packet_out = mem[head];
  end

  always_ff @(posedge clock) begin
    if (reset && !squash && push)
      mem[tail] <= wr_pkt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (fu_packet_in.valid && !fu_ready)
        overflow_err <= 1'b1;
      if (push)
        tail <= nxt(tail);
      if (pop)
        head <= nxt(head);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fu_result_buffer.sv
// Bench for fu_result_buffer: DEPTH=2 and DEPTH=3 instances on shared
// stimulus, each checked every cycle against a queue model.
module tb_fu_result_buffer;
  import fu_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic          squash;
  logic          written;
  ex_wr_packet_t pkt_in;

  logic          rdy2, rdy3, err2, err3;
  ex_wr_packet_t out2, out3;
  logic [1:0]    cnt2, cnt3;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  ex_wr_packet_t q2[$];
  ex_wr_packet_t q3[$];
  bit e2 = 1'b0;
  bit e3 = 1'b0;

  always #5 clock = ~clock;

  fu_result_buffer #(.DEPTH(2)) u_d2 (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_packet_in(pkt_in), .fu_ready(rdy2),
    .ex_packet_out(out2), .written(written),
    .count(cnt2), .overflow_err(err2)
  );

  fu_result_buffer #(.DEPTH(3)) u_d3 (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_packet_in(pkt_in), .fu_ready(rdy3),
    .ex_packet_out(out3), .written(written),
    .count(cnt3), .overflow_err(err3)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue model: each entry is a result waiting for its grant.
  task automatic model_step(inout ex_wr_packet_t q[$], inout bit e,
                            input int d);
    ex_wr_packet_t p;
    bit ok;
    if (!reset) begin
      q.delete();
      e = 1'b0;
    end else if (squash) begin
      q.delete();
    end else begin
      ok = (q.size() < d);
      if (pkt_in.valid && !ok) e = 1'b1;
      if (written && q.size() > 0) void'(q.pop_front());
      if (pkt_in.valid && ok) begin
        p = pkt_in;
        p.valid = 1'b1;
        q.push_back(p);
      end
    end
  endtask

  always @(posedge clock) begin
    model_step(q2, e2, 2);
    model_step(q3, e3, 3);
    chk_en <= 1'b1;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("d2_count", 64'(cnt2), 64'(q2.size()));
      chk("d2_ready", 64'(rdy2), 64'(q2.size() < 2));
      chk("d2_out", 64'(out2), q2.size() > 0 ? 64'(q2[0]) : 64'd0);
      chk("d2_err", 64'(err2), 64'(e2));
      chk("d3_count", 64'(cnt3), 64'(q3.size()));
      chk("d3_ready", 64'(rdy3), 64'(q3.size() < 3));
      chk("d3_out", 64'(out3), q3.size() > 0 ? 64'(q3[0]) : 64'd0);
      chk("d3_err", 64'(err3), 64'(e3));
    end
  end

  task automatic step(input logic v, input logic [31:0] val,
                      input logic w, input logic sq = 1'b0,
                      input logic rst = 1'b1);
    pkt_in       = '0;
    pkt_in.valid = v;
    pkt_in.value = val;
    pkt_in.dest  = val[4:0];
    pkt_in.tag   = val[5:0] ^ 6'h2a;
    written      = w;
    squash       = sq;
    reset        = rst;
    @(posedge clock);
    #1;
  endtask

  initial begin
    pkt_in  = '0;
    written = 1'b0;
    squash  = 1'b0;
    reset   = 1'b0;

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_count", 64'(cnt2), 64'd0);
    chk("rst_ready", 64'(rdy2), 64'd1);
    chk("rst_valid", 64'(out2.valid), 64'd0);
    chk("rst_err", 64'(err2), 64'd0);

    step(1, 32'h11, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_a", 64'(out2.value), 64'h11);
      chk("hold_cnt", 64'(cnt2), 64'd1);
      step(0, 0, 0);
    end
    step(0, 0, 1);

    step(1, 32'h11, 0);
    step(1, 32'h22, 0);
    chk("full_cnt", 64'(cnt2), 64'd2);
    chk("full_rdy", 64'(rdy2), 64'd0);
    chk("d3_rdy", 64'(rdy3), 64'd1);
    step(0, 0, 1);
    chk("head_b", 64'(out2.value), 64'h22);
    chk("cnt_one", 64'(cnt2), 64'd1);
    step(0, 0, 1);
    chk("empty_v", 64'(out2.valid), 64'd0);
    chk("empty_c", 64'(cnt2), 64'd0);
    step(0, 0, 1);

    step(1, 32'h11, 0);
    step(1, 32'h33, 1);
    chk("swap_cnt", 64'(cnt2), 64'd1);
    chk("swap_head", 64'(out2.value), 64'h33);
    step(0, 0, 1);

    step(1, 32'h41, 0);
    step(1, 32'h42, 0);
    step(1, 32'h44, 1, 1);
    chk("sq_cnt", 64'(cnt2), 64'd0);
    chk("sq_valid", 64'(out2.valid), 64'd0);
    step(0, 0, 0);
    chk("sq_no_d", 64'(out2.valid), 64'd0);

    step(1, 32'h51, 0);
    step(1, 32'h52, 0);
    step(1, 32'h55, 0);
    chk("ovf_err", 64'(err2), 64'd1);
    chk("ovf_head", 64'(out2.value), 64'h51);
    chk("ovf_cnt", 64'(cnt2), 64'd2);
    chk("d3_no_ovf", 64'(err3), 64'd0);
    step(0, 0, 0, 1);
    chk("ovf_sticky", 64'(err2), 64'd1);
    step(0, 0, 0, 0, 0);
    chk("ovf_clr", 64'(err2), 64'd0);

    for (int i = 0; i < 10; i++)
      step(1, 32'h100 + i, (i % 3) != 0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 1);
    chk("wrap_empty", 64'(cnt3), 64'd0);

    step(1, 32'h61, 0);
    step(1, 32'h62, 0);
    step(0, 0, 1, 0, 0);
    chk("rst_mid", 64'(cnt3), 64'd0);
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
